// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants and state encodings shared by the PS/2 receiver and key decoder
package ps2_pkg;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [1:0] F_IDLE   = 2'd0;
  localparam logic [1:0] F_DATA   = 2'd1;
  localparam logic [1:0] F_PARITY = 2'd2;
  localparam logic [1:0] F_STOP   = 2'd3;
  localparam logic [1:0] D_BASE    = 2'd0;
  localparam logic [1:0] D_EXT     = 2'd1;
  localparam logic [1:0] D_BRK     = 2'd2;
  localparam logic [1:0] D_EXT_BRK = 2'd3;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronizes and glitch-filters the PS/2 pins, then assembles odd-parity frames with a mid-frame timeout
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       timeout
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [1:0] clk_sync, dat_sync;
  logic filt;
  logic [FW-1:0] fcnt;
  logic [1:0] st;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic par;
  logic [TW-1:0] tcnt;
  logic fall, din;
  assign din  = dat_sync[1];
  // the filtered level drops in the same cycle the strobe fires
  assign fall = filt & ~clk_sync[1] & (fcnt == F_MAX);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      filt       <= 1'b1;
      fcnt       <= '0;
      st         <= F_IDLE;
      bit_idx    <= '0;
      sh         <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      fcnt       <= (clk_sync[1] == filt || fcnt == F_MAX) ? '0 : fcnt + 1'b1;
      filt       <= (clk_sync[1] != filt && fcnt == F_MAX) ? clk_sync[1] : filt;
      tcnt       <= (st == F_IDLE || fall) ? '0 : tcnt + 1'b1;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      if (st != F_IDLE && !fall && tcnt == T_MAX) begin
        st        <= F_IDLE;
        frame_err <= 1'b1;
        timeout   <= 1'b1;
      end else if (fall) begin
        case (st)
          F_IDLE: begin
            st      <= din ? F_IDLE : F_DATA;
            bit_idx <= '0;
          end
          F_DATA: begin
            sh      <= {din, sh[7:1]};
            bit_idx <= bit_idx + 1'b1;
            st      <= (bit_idx == 3'd7) ? F_PARITY : F_DATA;
          end
          F_PARITY: begin
            par <= din;
            st  <= F_STOP;
          end
          F_STOP: begin
            st         <= F_IDLE;
            data       <= (din && (^sh ^ par)) ? sh : data;
            data_valid <= din && (^sh ^ par);
            frame_err  <= !(din && (^sh ^ par));
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 scan codes into held up/down levels and a space-driven pause toggle
// Define PS2_WASD_EN to also map W/S onto up/down.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up_key_press,
  output logic       down_key_press,
  output logic       pause,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);
  logic [7:0] rx_byte;
  logic rx_valid, rx_timeout;
  logic [1:0] dstate;
  logic arrow_up, arrow_down, space_held;
  ps2_rx_frame #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (rx_byte),
    .data_valid (rx_valid),
    .frame_err  (frame_err),
    .timeout    (rx_timeout)
  );
  logic base_k, brk_k, ext_k, ext_brk_k;
  assign base_k    = rx_valid && dstate == D_BASE;
  assign brk_k     = rx_valid && dstate == D_BRK;
  assign ext_k     = rx_valid && dstate == D_EXT;
  assign ext_brk_k = rx_valid && dstate == D_EXT_BRK;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dstate     <= D_BASE;
      arrow_up   <= 1'b0;
      arrow_down <= 1'b0;
      space_held <= 1'b0;
      pause      <= 1'b0;
      key_code   <= '0;
      key_valid  <= 1'b0;
    end else begin
      key_valid <= rx_valid;
      key_code  <= rx_valid ? rx_byte : key_code;
      // a prefix byte in an unexpected state completes the code and drops back to BASE
      dstate <= rx_timeout ? D_BASE :
                !rx_valid ? dstate :
                (rx_byte == SC_EXT && dstate == D_BASE) ? D_EXT :
                (rx_byte == SC_BREAK && dstate == D_BASE) ? D_BRK :
                (rx_byte == SC_BREAK && dstate == D_EXT) ? D_EXT_BRK : D_BASE;
      arrow_up   <= (ext_k && rx_byte == SC_UP) ? 1'b1 : (ext_brk_k && rx_byte == SC_UP) ? 1'b0 : arrow_up;
      arrow_down <= (ext_k && rx_byte == SC_DOWN) ? 1'b1 : (ext_brk_k && rx_byte == SC_DOWN) ? 1'b0 : arrow_down;
      pause      <= (base_k && rx_byte == SC_SPACE && !space_held) ? ~pause : pause;
      space_held <= (base_k && rx_byte == SC_SPACE) ? 1'b1 : (brk_k && rx_byte == SC_SPACE) ? 1'b0 : space_held;
    end
  end
`ifdef PS2_WASD_EN
  logic w_held, s_held;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_held <= 1'b0;
      s_held <= 1'b0;
    end else begin
      w_held <= (base_k && rx_byte == SC_W) ? 1'b1 : (brk_k && rx_byte == SC_W) ? 1'b0 : w_held;
      s_held <= (base_k && rx_byte == SC_S) ? 1'b1 : (brk_k && rx_byte == SC_S) ? 1'b0 : s_held;
    end
  end
  assign up_key_press   = arrow_up | w_held;
  assign down_key_press = arrow_down | s_held;
`else
  assign up_key_press   = arrow_up;
  assign down_key_press = arrow_down;
`endif
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: vector table, corner-case sequences and random key events against an event-level model
module tb_ps2_key_decoder;
  localparam int HALF = 15;
  localparam int TO   = 3000;
`ifdef PS2_WASD_EN
  localparam bit WASD = 1'b1;
`else
  localparam bit WASD = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic up_key_press, down_key_press, pause, key_valid, frame_err;
  logic [7:0] key_code;
  int n_cmp = 0, n_bad = 0, kv_cnt = 0, er_cnt = 0;
  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up_key_press(up_key_press), .down_key_press(down_key_press), .pause(pause),
    .key_code(key_code), .key_valid(key_valid), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) er_cnt++;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bad = 1'b0, input int nbits = 11);
    logic [10:0] f;
    f = {1'b1, bad ? ^b : ~^b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk) ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    repeat (40) @(posedge clk);
    ps2_data = 1'b1;
  endtask
  task automatic chk_out(input string nm, input bit up, input bit dn, input bit pz, input logic [7:0] code);
    @(negedge clk);
    chk({nm, ".up"}, 32'(up_key_press), 32'(up));
    chk({nm, ".down"}, 32'(down_key_press), 32'(dn));
    chk({nm, ".pause"}, 32'(pause), 32'(pz));
    chk({nm, ".code"}, 32'(key_code), 32'(code));
  endtask
  typedef struct {
    logic [7:0] b;
    bit bad, up, dn, pz;
    logic [7:0] code;
    int kv, er;
  } vec_t;
  vec_t tbl[14];
  bit m_up, m_dn, m_pz, m_sp, m_w, m_s;
  logic [7:0] m_code;
  initial begin
    int kv0, er0;
    tbl[0]  = '{8'hE0, 0, 0, 0, 0, 8'hE0, 1, 0};
    tbl[1]  = '{8'h75, 0, 1, 0, 0, 8'h75, 1, 0};
    tbl[2]  = '{8'hE0, 0, 1, 0, 0, 8'hE0, 1, 0};
    tbl[3]  = '{8'hF0, 0, 1, 0, 0, 8'hF0, 1, 0};
    tbl[4]  = '{8'h75, 0, 0, 0, 0, 8'h75, 1, 0};
    tbl[5]  = '{8'h29, 0, 0, 0, 1, 8'h29, 1, 0};
    tbl[6]  = '{8'h29, 0, 0, 0, 1, 8'h29, 1, 0};
    tbl[7]  = '{8'h29, 0, 0, 0, 1, 8'h29, 1, 0};
    tbl[8]  = '{8'hF0, 0, 0, 0, 1, 8'hF0, 1, 0};
    tbl[9]  = '{8'h29, 0, 0, 0, 1, 8'h29, 1, 0};
    tbl[10] = '{8'h29, 0, 0, 0, 0, 8'h29, 1, 0};
    tbl[11] = '{8'h72, 1, 0, 0, 0, 8'h29, 0, 1};
    tbl[12] = '{8'hE0, 0, 0, 0, 0, 8'hE0, 1, 0};
    tbl[13] = '{8'h72, 0, 0, 1, 0, 8'h72, 1, 0};
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst.up", 32'(up_key_press), 0);
    chk("rst.down", 32'(down_key_press), 0);
    chk("rst.pause", 32'(pause), 0);
    chk("rst.code", 32'(key_code), 0);
    chk("rst.valid", 32'(key_valid), 0);
    chk("rst.err", 32'(frame_err), 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      kv0 = kv_cnt;
      er0 = er_cnt;
      send(tbl[i].b, tbl[i].bad);
      chk_out($sformatf("vec%0d", i), tbl[i].up, tbl[i].dn, tbl[i].pz, tbl[i].code);
      chk($sformatf("vec%0d.kv_pulses", i), 32'(kv_cnt - kv0), 32'(tbl[i].kv));
      chk($sformatf("vec%0d.err_pulses", i), 32'(er_cnt - er0), 32'(tbl[i].er));
    end
    send(8'hE0);
    kv0 = kv_cnt;
    er0 = er_cnt;
    send(8'h75, 1'b0, 5);
    repeat (TO + 200) @(posedge clk);
    chk("timeout.err_pulses", 32'(er_cnt - er0), 1);
    chk("timeout.kv_pulses", 32'(kv_cnt - kv0), 0);
    send(8'h75);
    chk_out("timeout.prefix_cleared", 0, 1, 0, 8'h75);
    send(8'hE0);
    send(8'h75);
    chk_out("timeout.recover", 1, 1, 0, 8'h75);
    send(8'h29, 1'b0, 6);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst.up", 32'(up_key_press), 0);
    chk("midrst.down", 32'(down_key_press), 0);
    chk("midrst.code", 32'(key_code), 0);
    chk("midrst.valid", 32'(key_valid), 0);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h29);
    chk_out("midrst.after", 0, 0, 1, 8'h29);
    send(8'h1D);
    chk_out("wasd.w_make", WASD, 0, 1, 8'h1D);
    send(8'h1B);
    chk_out("wasd.s_make", WASD, WASD, 1, 8'h1B);
    send(8'hF0);
    send(8'h1D);
    chk_out("wasd.w_break", 0, WASD, 1, 8'h1D);
    send(8'hF0);
    send(8'h1B);
    chk_out("wasd.s_break", 0, 0, 1, 8'h1B);
    m_up = 0; m_dn = 0; m_pz = 1; m_sp = 1; m_w = 0; m_s = 0;
    send(8'hF0);
    send(8'h29);
    m_sp = 0;
    for (int e = 0; e < 30; e++) begin
      int ev;
      logic [7:0] k;
      bit brk;
      ev  = int'($urandom_range(0, 6));
      brk = 1'($urandom_range(0, 1));
      case (ev)
        0: k = 8'h75;
        1: k = 8'h72;
        2: k = 8'h29;
        3: k = 8'h1D;
        4: k = 8'h1B;
        5: k = 8'h1C;
        default: k = 8'h4B;
      endcase
      if (ev <= 1) send(8'hE0);
      if (brk) send(8'hF0);
      send(k);
      m_code = k;
      if (ev == 0) m_up = !brk;
      if (ev == 1) m_dn = !brk;
      if (ev == 2) begin
        if (!brk && !m_sp) m_pz = !m_pz;
        m_sp = !brk;
      end
      if (ev == 3 && WASD) m_w = !brk;
      if (ev == 4 && WASD) m_s = !brk;
      chk_out($sformatf("rand%0d", e), m_up | m_w, m_dn | m_s, m_pz, m_code);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
